// File: rtl/gpio_irq_6502.sv
// -----------------------------------------------------------------------------
// gpio_irq_6502
//
// Memory-mapped GPIO block with per-bit interrupt detection for a 6502-style
// bus. Every clock is a bus cycle: rd_wr_i selects read (0) or write (1) of
// the register at address_i. Each port occupies eight bytes starting at
// BaseAddress + 8*p:
//   +0 IN        synchronized pin state (read only)
//   +1 OUT       drives ex_data_o
//   +2 IRQ_EN    per-bit interrupt enable
//   +3 EDGE_SEL  1 = edge triggered, 0 = level triggered
//   +4 POL       0 = rising/high active, 1 = falling/low active
//   +5 STATUS    latched interrupt flags, write 1 to clear
//   +6/+7        unmapped
//
// Ports:
//   clk_i            sole clock, rising edge
//   reset_i          synchronous, active-high reset
//   address_i        CPU bus address
//   data_i           CPU write data
//   data_o           registered read data (0 when no read hit)
//   rd_wr_i          0 = read cycle, 1 = write cycle
//   ex_data_i        asynchronous pins, port p at [p*data_width +: data_width]
//   ex_data_o        OUT registers, same packing
//   irq_o            registered OR of all STATUS bits
//   take_controlr_o  read hit, aligned with data_o
//   take_controlw_o  one-cycle pulse per write hit
// -----------------------------------------------------------------------------
module gpio_irq_6502 #(
    parameter int BaseAddress   = 0,
    parameter int address_width = 16,
    parameter int data_width    = 8,
    parameter int NumPorts      = 2,
    parameter int SyncStages    = 2
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [address_width-1:0]       address_i,
    input  logic [data_width-1:0]          data_i,
    output logic [data_width-1:0]          data_o,
    input  logic                           rd_wr_i,
    input  logic [NumPorts*data_width-1:0] ex_data_i,
    output logic [NumPorts*data_width-1:0] ex_data_o,
    output logic                           irq_o,
    output logic                           take_controlr_o,
    output logic                           take_controlw_o
);

    localparam int AW1 = address_width + 1;
    localparam int PW  = NumPorts * data_width;
    localparam logic [AW1-1:0] BASE     = AW1'(BaseAddress);
    localparam logic [AW1-1:0] MAP_SIZE = AW1'(8 * NumPorts);

    typedef enum logic [2:0] {
        REG_IN       = 3'd0,
        REG_OUT      = 3'd1,
        REG_IRQ_EN   = 3'd2,
        REG_EDGE_SEL = 3'd3,
        REG_POL      = 3'd4,
        REG_STATUS   = 3'd5,
        REG_RSVD6    = 3'd6,
        REG_RSVD7    = 3'd7
    } reg_sel_e;

    // ---------------------------------------------------------------- decode
    // One extra bit on the subtraction: an address below the base wraps to a
    // value far above MAP_SIZE, so a single compare covers both map bounds.
    logic [AW1-1:0] rel;
    logic           hit;
    logic [2:0]     port_sel;
    reg_sel_e       reg_sel;
    logic           wr_en;
    logic           rd_hit;
    logic           wr_hit;

    assign rel      = {1'b0, address_i} - BASE;
    assign hit      = rel < MAP_SIZE;
    assign port_sel = rel[5:3];
    assign reg_sel  = reg_sel_e'(rel[2:0]);
    assign wr_en    = hit && rd_wr_i;
    assign rd_hit   = hit && !rd_wr_i && (reg_sel <= REG_STATUS);
    assign wr_hit   = wr_en && (reg_sel != REG_IN) && (reg_sel <= REG_STATUS);

    // ----------------------------------------------------------------- state
    logic [PW-1:0]         sync_q [SyncStages];
    logic [PW-1:0]         prev_q;
    logic [data_width-1:0] out_q      [NumPorts];
    logic [data_width-1:0] irq_en_q   [NumPorts];
    logic [data_width-1:0] edge_sel_q [NumPorts];
    logic [data_width-1:0] pol_q      [NumPorts];
    logic [data_width-1:0] status_q   [NumPorts];
    logic [data_width-1:0] status_d   [NumPorts];
    logic [data_width-1:0] in_val     [NumPorts];

    // ------------------------------------------------------ per-port events
    for (genvar p = 0; p < NumPorts; p++) begin : g_port
        logic [data_width-1:0] sync_v;
        logic [data_width-1:0] prev_v;
        logic [data_width-1:0] active;
        logic [data_width-1:0] fire;
        logic [data_width-1:0] w1c;

        assign sync_v = sync_q[SyncStages-1][p*data_width +: data_width];
        assign prev_v = prev_q[p*data_width +: data_width];
        // A bit is "active" when it sits at the level opposite to POL.
        assign active = sync_v ^ pol_q[p];
        // Edge mode additionally needs the bit to have just changed.
        assign fire   = active & (~edge_sel_q[p] | (sync_v ^ prev_v));
        assign w1c    = (wr_en && port_sel == 3'(p) && reg_sel == REG_STATUS)
                        ? data_i : '0;
        // Clear first, then set: a new event wins over a same-cycle W1C.
        assign status_d[p] = (status_q[p] & ~w1c) | (fire & irq_en_q[p]);
        assign in_val[p]   = sync_v;
        assign ex_data_o[p*data_width +: data_width] = out_q[p];
    end

    // ------------------------------------------------------------- read mux
    logic [data_width-1:0] rd_data;
    logic                  irq_any;

    // NOTE: every output of an always_comb gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_data = '0;
        irq_any = 1'b0;
        for (int p = 0; p < NumPorts; p++) begin
            irq_any = irq_any | (|status_q[p]);
            if (port_sel == 3'(p)) begin
                case (reg_sel)
                    REG_IN:       rd_data = in_val[p];
                    REG_OUT:      rd_data = out_q[p];
                    REG_IRQ_EN:   rd_data = irq_en_q[p];
                    REG_EDGE_SEL: rd_data = edge_sel_q[p];
                    REG_POL:      rd_data = pol_q[p];
                    REG_STATUS:   rd_data = status_q[p];
                    default:      rd_data = '0;
                endcase
            end
        end
    end

    // ------------------------------------------------------------ registers
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int s = 0; s < SyncStages; s++) sync_q[s] <= '0;
            prev_q <= '0;
            for (int p = 0; p < NumPorts; p++) begin
                out_q[p]      <= '0;
                irq_en_q[p]   <= '0;
                edge_sel_q[p] <= '0;
                pol_q[p]      <= '0;
                status_q[p]   <= '0;
            end
            data_o          <= '0;
            take_controlr_o <= 1'b0;
            take_controlw_o <= 1'b0;
            irq_o           <= 1'b0;
        end else begin
            sync_q[0] <= ex_data_i;
            for (int s = 1; s < SyncStages; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= sync_q[SyncStages-1];
            for (int p = 0; p < NumPorts; p++) begin
                status_q[p] <= status_d[p];
                if (wr_hit && port_sel == 3'(p)) begin
                    case (reg_sel)
                        REG_OUT:      out_q[p]      <= data_i;
                        REG_IRQ_EN:   irq_en_q[p]   <= data_i;
                        REG_EDGE_SEL: edge_sel_q[p] <= data_i;
                        REG_POL:      pol_q[p]      <= data_i;
                        default:      ;
                    endcase
                end
            end
            data_o          <= rd_hit ? rd_data : '0;
            take_controlr_o <= rd_hit;
            take_controlw_o <= wr_hit;
            irq_o           <= irq_any;
        end
    end

endmodule

// File: tb/tb_gpio_irq_6502.sv
// -----------------------------------------------------------------------------
// tb_gpio_irq_6502
//
// Directed scenario tasks followed by a randomized run compared against a
// behavioural model that works from pin history and register contents.
// -----------------------------------------------------------------------------
module tb_gpio_irq_6502;

    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int NP   = 2;
    localparam int SS   = 2;
    localparam int BASE = 'h0100;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic [AW-1:0]     address_i;
    logic [DW-1:0]     data_i;
    logic [DW-1:0]     data_o;
    logic              rd_wr_i;
    logic [NP*DW-1:0]  ex_data_i;
    logic [NP*DW-1:0]  ex_data_o;
    logic              irq_o;
    logic              take_controlr_o;
    logic              take_controlw_o;

    gpio_irq_6502 #(
        .BaseAddress  (BASE),
        .address_width(AW),
        .data_width   (DW),
        .NumPorts     (NP),
        .SyncStages   (SS)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .address_i      (address_i),
        .data_i         (data_i),
        .data_o         (data_o),
        .rd_wr_i        (rd_wr_i),
        .ex_data_i      (ex_data_i),
        .ex_data_o      (ex_data_o),
        .irq_o          (irq_o),
        .take_controlr_o(take_controlr_o),
        .take_controlw_o(take_controlw_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    logic [NP*DW-1:0] pins = '0;

    // ------------------------------------------------------ reference model
    // m_hist[0] is the pin value sampled at the most recent edge, m_hist[i]
    // the one sampled i edges earlier. The synchronized value the block acts
    // on is m_hist[SS-1], and the previous one is m_hist[SS].
    logic [DW-1:0]    m_out    [NP];
    logic [DW-1:0]    m_en     [NP];
    logic [DW-1:0]    m_edge   [NP];
    logic [DW-1:0]    m_pol    [NP];
    logic [DW-1:0]    m_status [NP];
    logic [NP*DW-1:0] m_hist   [SS+1];
    logic [DW-1:0]    e_data;
    logic             e_rd, e_wr, e_irq;

    function automatic logic [NP*DW-1:0] m_ex();
        logic [NP*DW-1:0] r;
        for (int p = 0; p < NP; p++) r[p*DW +: DW] = m_out[p];
        return r;
    endfunction

    task automatic model_step(input logic rst, input logic [AW-1:0] addr,
                              input logic rw, input logic [DW-1:0] wd);
        int rel, port, off;
        logic [DW-1:0] s, pv, fire, nxt;
        if (rst) begin
            for (int p = 0; p < NP; p++) begin
                m_out[p] = '0; m_en[p] = '0; m_edge[p] = '0;
                m_pol[p] = '0; m_status[p] = '0;
            end
            for (int h = 0; h <= SS; h++) m_hist[h] = '0;
            e_data = '0; e_rd = 1'b0; e_wr = 1'b0; e_irq = 1'b0;
            return;
        end
        rel  = int'(addr) - BASE;
        port = (rel >= 0 && rel < 8 * NP) ? rel / 8 : -1;
        off  = rel & 7;
        e_irq = 1'b0;
        for (int p = 0; p < NP; p++) if (m_status[p] != 0) e_irq = 1'b1;
        e_rd = 1'b0; e_data = '0; e_wr = 1'b0;
        if (port >= 0 && !rw && off <= 5) begin
            e_rd = 1'b1;
            case (off)
                0: e_data = m_hist[SS-1][port*DW +: DW];
                1: e_data = m_out[port];
                2: e_data = m_en[port];
                3: e_data = m_edge[port];
                4: e_data = m_pol[port];
                default: e_data = m_status[port];
            endcase
        end
        for (int p = 0; p < NP; p++) begin
            s = m_hist[SS-1][p*DW +: DW];
            pv = m_hist[SS][p*DW +: DW];
            fire = '0;
            for (int b = 0; b < DW; b++)
                if (s[b] != m_pol[p][b] && (!m_edge[p][b] || s[b] != pv[b])) fire[b] = 1'b1;
            nxt = m_status[p];
            if (rw && port == p && off == 5) nxt = nxt & ~wd;
            m_status[p] = nxt | (fire & m_en[p]);
        end
        if (rw && port >= 0 && off >= 1 && off <= 5) begin
            e_wr = 1'b1;
            case (off)
                1: m_out[port]  = wd;
                2: m_en[port]   = wd;
                3: m_edge[port] = wd;
                4: m_pol[port]  = wd;
                default: ;
            endcase
        end
        for (int h = SS; h > 0; h--) m_hist[h] = m_hist[h-1];
        m_hist[0] = pins;
    endtask

    // ------------------------------------------------------------ bus tasks
    function automatic logic [AW-1:0] reg_addr(input int p, input int r);
        return AW'(BASE + 8 * p + r);
    endfunction

    task automatic cycle(input logic rst, input logic [AW-1:0] addr,
                         input logic rw, input logic [DW-1:0] wd);
        reset_i = rst; address_i = addr; rd_wr_i = rw; data_i = wd;
        ex_data_i = pins;
        model_step(rst, addr, rw, wd);
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] d);
        cycle(1'b0, addr, 1'b1, d);
    endtask

    task automatic rd(input logic [AW-1:0] addr);
        cycle(1'b0, addr, 1'b0, '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0);
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        pins = '0;
        cycle(1'b1, reg_addr(1, 1), 1'b1, 8'hFF);
        cycle(1'b1, reg_addr(0, 2), 1'b1, 8'hFF);
        checks++;
        if (data_o !== 8'h00 || take_controlr_o !== 1'b0 || take_controlw_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus: data_o=%h rd=%b wr=%b required 00 0 0",
                     data_o, take_controlr_o, take_controlw_o);
        end
        checks++;
        if (irq_o !== 1'b0 || ex_data_o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: irq_o=%b ex_data_o=%h required 0 0000", irq_o, ex_data_o);
        end
        rd(reg_addr(1, 1));
        checks++;
        if (data_o !== 8'h00 || take_controlr_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_out_read: data_o=%h rd=%b required 00 1", data_o, take_controlr_o);
        end
    endtask

    task automatic test_out_write();
        wr(reg_addr(1, 1), 8'hA5);
        checks++;
        if (ex_data_o !== 16'hA500 || take_controlw_o !== 1'b1) begin
            errors++;
            $display("FAIL out_write: ex_data_o=%h wr=%b required a500 1", ex_data_o, take_controlw_o);
        end
        rd(reg_addr(1, 1));
        checks++;
        if (data_o !== 8'hA5 || take_controlr_o !== 1'b1 || take_controlw_o !== 1'b0) begin
            errors++;
            $display("FAIL out_readback: data_o=%h rd=%b wr=%b required a5 1 0",
                     data_o, take_controlr_o, take_controlw_o);
        end
        wr(reg_addr(1, 0), 8'h3C);
        checks++;
        if (take_controlw_o !== 1'b0 || ex_data_o !== 16'hA500) begin
            errors++;
            $display("FAIL in_write_ignored: wr=%b ex_data_o=%h required 0 a500",
                     take_controlw_o, ex_data_o);
        end
    endtask

    task automatic test_edge();
        wr(reg_addr(0, 3), 8'h01);
        wr(reg_addr(0, 4), 8'h00);
        wr(reg_addr(0, 2), 8'h01);
        pins[0] = 1'b1;
        idle(1);                       // edge k
        idle(1);                       // edge k+1
        rd(reg_addr(0, 5));            // edge k+2: read sees pre-edge STATUS
        checks++;
        if (data_o !== 8'h00 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL edge_early: status=%h irq=%b required 00 0", data_o, irq_o);
        end
        rd(reg_addr(0, 5));            // edge k+3
        checks++;
        if (data_o !== 8'h01 || irq_o !== 1'b1) begin
            errors++;
            $display("FAIL edge_set: status=%h irq=%b required 01 1", data_o, irq_o);
        end
        wr(reg_addr(0, 5), 8'h01);
        idle(1);
        rd(reg_addr(0, 5));
        checks++;
        if (data_o !== 8'h00 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL edge_cleared: status=%h irq=%b required 00 0", data_o, irq_o);
        end
    endtask

    task automatic test_level();
        wr(reg_addr(0, 2), 8'h08);
        wr(reg_addr(0, 3), 8'h00);
        wr(reg_addr(0, 4), 8'h08);
        idle(3);
        wr(reg_addr(0, 5), 8'h08);
        rd(reg_addr(0, 5));
        checks++;
        if (data_o !== 8'h08 || irq_o !== 1'b1) begin
            errors++;
            $display("FAIL level_persist: status=%h irq=%b required 08 1", data_o, irq_o);
        end
        pins[3] = 1'b1;
        idle(3);
        wr(reg_addr(0, 5), 8'h08);
        rd(reg_addr(0, 5));
        checks++;
        if (data_o !== 8'h00) begin
            errors++;
            $display("FAIL level_cleared: status=%h required 00", data_o);
        end
        idle(1);
        checks++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("FAIL level_irq_low: irq=%b required 0", irq_o);
        end
    endtask

    task automatic test_mask();
        pins[15:8] = 8'hFF;
        idle(4);
        rd(reg_addr(1, 5));
        checks++;
        if (data_o !== 8'h00 || irq_o !== 1'b0 || take_controlr_o !== 1'b1) begin
            errors++;
            $display("FAIL mask_status: status=%h irq=%b rd=%b required 00 0 1",
                     data_o, irq_o, take_controlr_o);
        end
        rd(reg_addr(1, 1));
        rd(reg_addr(0, 6));
        checks++;
        if (data_o !== 8'h00 || take_controlr_o !== 1'b0) begin
            errors++;
            $display("FAIL unmapped_read_6: data_o=%h rd=%b required 00 0", data_o, take_controlr_o);
        end
        rd(reg_addr(1, 1));
        rd(reg_addr(1, 7));
        checks++;
        if (data_o !== 8'h00 || take_controlr_o !== 1'b0) begin
            errors++;
            $display("FAIL unmapped_read_7: data_o=%h rd=%b required 00 0", data_o, take_controlr_o);
        end
        rd(AW'(BASE - 1));
        checks++;
        if (take_controlr_o !== 1'b0) begin
            errors++;
            $display("FAIL below_base_read: rd=%b required 0", take_controlr_o);
        end
        rd(AW'(BASE + 8 * NP));
        checks++;
        if (take_controlr_o !== 1'b0) begin
            errors++;
            $display("FAIL above_map_read: rd=%b required 0", take_controlr_o);
        end
        wr(reg_addr(0, 6), 8'hFF);
        checks++;
        if (take_controlw_o !== 1'b0) begin
            errors++;
            $display("FAIL unmapped_write: wr=%b required 0", take_controlw_o);
        end
    endtask

    task automatic test_collision();
        wr(reg_addr(0, 2), 8'h04);
        wr(reg_addr(0, 3), 8'h04);
        wr(reg_addr(0, 4), 8'h00);
        pins[2] = 1'b1;
        idle(3);                       // first rising edge latched
        pins[2] = 1'b0;
        idle(2);
        pins[2] = 1'b1;
        idle(2);                       // edges m, m+1
        wr(reg_addr(0, 5), 8'h04);     // edge m+2: W1C meets new event
        rd(reg_addr(0, 5));
        checks++;
        if (data_o !== 8'h04 || irq_o !== 1'b1) begin
            errors++;
            $display("FAIL collision_set_wins: status=%h irq=%b required 04 1", data_o, irq_o);
        end
        wr(reg_addr(0, 5), 8'h04);
        rd(reg_addr(0, 5));
        checks++;
        if (data_o !== 8'h00) begin
            errors++;
            $display("FAIL collision_w1c: status=%h required 00", data_o);
        end
    endtask

    task automatic test_reset_mid();
        // pins[7:0] are 0x0D here; POL = ~pins makes every bit level-active.
        wr(reg_addr(0, 3), 8'h00);
        wr(reg_addr(0, 4), 8'hF2);
        wr(reg_addr(0, 2), 8'hFF);
        idle(3);
        rd(reg_addr(0, 5));
        checks++;
        if (data_o !== 8'hFF || irq_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_status: status=%h irq=%b required ff 1", data_o, irq_o);
        end
        cycle(1'b1, reg_addr(0, 1), 1'b1, 8'h77);
        checks++;
        if (irq_o !== 1'b0 || data_o !== 8'h00 || ex_data_o !== 16'h0000 ||
            take_controlw_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: irq=%b data_o=%h ex=%h wr=%b required 0 00 0000 0",
                     irq_o, data_o, ex_data_o, take_controlw_o);
        end
        rd(reg_addr(0, 5));
        checks++;
        if (data_o !== 8'h00 || take_controlr_o !== 1'b1 || irq_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_status: status=%h rd=%b irq=%b required 00 1 0",
                     data_o, take_controlr_o, irq_o);
        end
        rd(reg_addr(0, 2));
        checks++;
        if (data_o !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_irq_en: data_o=%h required 00", data_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            wr(reg_addr(0, 1), vals[i]);
            checks++;
            if (take_controlw_o !== 1'b1 || ex_data_o[7:0] !== vals[i]) begin
                errors++;
                $display("FAIL b2b_write_%0d: wr=%b ex=%h required 1 %h",
                         i, take_controlw_o, ex_data_o[7:0], vals[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            rd(reg_addr(0, 1));
            checks++;
            if (take_controlr_o !== 1'b1 || data_o !== 8'h33) begin
                errors++;
                $display("FAIL b2b_read_%0d: rd=%b data_o=%h required 1 33",
                         i, take_controlr_o, data_o);
            end
        end
        wr(reg_addr(0, 1), 8'h44);
        rd(reg_addr(0, 1));
        checks++;
        if (take_controlr_o !== 1'b1 || take_controlw_o !== 1'b0 || data_o !== 8'h44) begin
            errors++;
            $display("FAIL b2b_wr_then_rd: rd=%b wr=%b data_o=%h required 1 0 44",
                     take_controlr_o, take_controlw_o, data_o);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] addr;
        logic          rw, rst;
        for (int n = 0; n < 600; n++) begin
            rst  = ($urandom_range(0, 59) == 0);
            addr = AW'(BASE - 4 + int'($urandom_range(0, 8 * NP + 8)));
            rw   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) pins = (NP*DW)'($urandom);
            cycle(rst, addr, rw, DW'($urandom));
            checks++;
            if (data_o !== e_data || take_controlr_o !== e_rd || take_controlw_o !== e_wr ||
                irq_o !== e_irq || ex_data_o !== m_ex()) begin
                errors++;
                $display("FAIL random_%0d: data_o=%h rd=%b wr=%b irq=%b ex=%h required %h %b %b %b %h",
                         n, data_o, take_controlr_o, take_controlw_o, irq_o, ex_data_o,
                         e_data, e_rd, e_wr, e_irq, m_ex());
            end
        end
    endtask

    initial begin
        test_reset();
        test_out_write();
        test_edge();
        test_level();
        test_mask();
        test_collision();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
